// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// and data-memory wait handling with a timeout that parks in an error state.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  drs1,
    input  logic [4:0]  drs2,
    input  logic [4:0]  ers1,
    input  logic [4:0]  ers2,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic [4:0]  wrn,
    input  logic        wwreg,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        bubble_w,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state
);

    localparam int unsigned RW = 5;
    localparam int unsigned WW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERR     = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            timeout_q, timeout_d;
    logic            load_use;

    // M result wins over W result; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] rs,
        input logic          m_we,
        input logic [RW-1:0] m_rd,
        input logic          w_we,
        input logic [RW-1:0] w_rd
    );
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign load_use = em2reg && ewreg && (ern != '0) && ((ern == drs1) || (ern == drs2));

    // Next-state and combinational control outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        bubble_w  = 1'b0;
        fwd_a     = fwd_sel(ers1, mwreg, mrn, wwreg, wrn);
        fwd_b     = fwd_sel(ers2, mwreg, mrn, wwreg, wrn);

        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    {stall_f, stall_d, stall_e, stall_m, bubble_w} = 5'b11111;
                    state_d = ST_MEMWAIT;
                    wait_d  = '0;
                end else if (branch_taken) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                {stall_f, stall_d, stall_e, stall_m, bubble_w} = 5'b11111;
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_q == '1) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_ERR: begin
                {stall_f, stall_d, stall_e, stall_m, bubble_w} = 5'b11111;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset forces every combinational control output quiet.
        if (!rst_n) begin
            {stall_f, stall_d, stall_e, stall_m, bubble_w} = 5'b00000;
            flush_d = 1'b0;
            flush_e = 1'b0;
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
        end

        stall_cnt_d = (stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + CW'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign mem_timeout = timeout_q;

endmodule
